// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  // Multiplier control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the iteration counter. It is sized to hold W, so it never wraps
  // within one operation.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cla_adder.sv
// Unsigned carry-lookahead adder: sum = a + b, with a (W+1)-bit result so the
// carry out is always kept.
module cla_adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH:0]   sum
);

  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] p;
  logic [DATA_WIDTH-1:0] carry_in;
  logic                  carry_out;

  assign g = a & b;
  assign p = a ^ b;

  // Carry for each bit, derived from the generate/propagate terms.
  always_comb begin
    logic carry;
    carry    = 1'b0;
    carry_in = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      carry_in[i] = carry;
      carry       = g[i] | (p[i] & carry);
    end
    carry_out = carry;
  end

  assign sum = {carry_out, p ^ carry_in};

endmodule

// File: rtl/seq_shift_add_mult.sv
// Multi-cycle unsigned shift-and-add multiplier with valid/ready handshakes on
// the input and output sides.
// Each operation takes DATA_WIDTH accumulate cycles. The whole product is
// presented at once, only when the operation is complete.
// Optional feature macro: CLMUL_MODE_EN. When it is defined, the block gets a
// 'clmul' input. That input selects carry-less (GF(2)) accumulation for each
// operation.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_prod
`ifdef CLMUL_MODE_EN
  ,
  input  logic                    clmul
`endif
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] addend;
  logic [DATA_WIDTH:0]   sum_add;
  logic [DATA_WIDTH:0]   acc;
  logic                  take_in;
  logic                  give_out;

`ifdef CLMUL_MODE_EN
  logic                  clmul_q;
`endif

  assign take_in  = in_valid & in_ready;
  assign give_out = out_valid & out_ready;

  // The multiplier's low bit selects whether the multiplicand is added this cycle.
  assign addend = lo_q[0] ? a_q : '0;

  cla_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_add (
    .a  (hi_q),
    .b  (addend),
    .sum(sum_add)
  );

`ifdef CLMUL_MODE_EN
  // Carry-less accumulation is a plain XOR with no carry out. It is muxed in
  // ahead of the register, in place of the integer sum.
  assign acc = clmul_q ? {1'b0, hi_q ^ addend} : sum_add;
`else
  assign acc = sum_add;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (take_in) state_d = BUSY;
      end
      BUSY: begin
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (give_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hide the accumulator contents until the product is complete.
  assign out_prod = out_valid ? {hi_q, lo_q} : '0;

  // Operand capture, then one shift-and-add step per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
`ifdef CLMUL_MODE_EN
      clmul_q <= 1'b0;
`endif
    end else if (state_q == IDLE) begin
      if (take_in) begin
        a_q     <= in_a;
        hi_q    <= '0;
        lo_q    <= in_b;
        cnt_q   <= '0;
`ifdef CLMUL_MODE_EN
        clmul_q <= clmul;
`endif
      end
    end else if (state_q == BUSY) begin
      hi_q  <= acc[DATA_WIDTH:1];
      lo_q  <= {acc[0], lo_q[DATA_WIDTH-1:1]};
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult (DATA_WIDTH=8). Define CLMUL_MODE_EN
// to exercise the carry-less mode.
`timescale 1ns/1ps
module tb_seq_shift_add_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic           clmul;

  seq_shift_add_mult #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prod (out_prod)
`ifdef CLMUL_MODE_EN
    ,
    .clmul    (clmul)
`endif
  );

  always #5 clk = ~clk;

  int             cyc = 0;
  int             n_cmp = 0;
  int             n_err = 0;
  logic [2*W-1:0] exp_q[$];
  int             hs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: handshake timing, hold stability and product checks.
  logic           prev_valid = 1'b0;
  logic           prev_ready = 1'b0;
  logic [2*W-1:0] held = '0;
  logic           chk_ready_next = 1'b0;

  always @(negedge clk) begin
    if (chk_ready_next) begin
      check("in_ready_after_xfer", 32'(in_ready), 32'd1);
      chk_ready_next = 1'b0;
    end
    if (out_valid) begin
      check("in_ready_in_done", 32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!prev_valid)
          check("latency_edges", 32'(cyc - hs_q[0]), 32'(W));
        if (!out_ready) begin
          if (prev_valid && !prev_ready)
            check("prod_hold", 32'(out_prod), 32'(held));
          held = out_prod;
        end else begin
          check("product", 32'(out_prod), 32'(exp_q.pop_front()));
          void'(hs_q.pop_front());
          chk_ready_next = 1'b1;
        end
      end
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
  end

  // Present operands until accepted; scramble them right after capture.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cm, input logic [2*W-1:0] exp, input bit push);
    int n;
    in_a = a; in_b = b; clmul = cm; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); clmul = 1'($urandom);
    if (push) begin
      exp_q.push_back(exp);
      hs_q.push_back(cyc);
    end
  endtask

  task automatic scramble(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_a = W'($urandom); in_b = W'($urandom);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      hs_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; clmul = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_prod", 32'(out_prod), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Integer products.
    issue(8'd13, 8'd11, 1'b0, 16'h008F, 1'b1); wait_drain();
    issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1); wait_drain();
    issue(8'h00, 8'hA5, 1'b0, 16'h0000, 1'b1); wait_drain();
    issue(8'h01, 8'h80, 1'b0, 16'h0080, 1'b1); wait_drain();
    issue(8'h80, 8'hFF, 1'b0, 16'h7F80, 1'b1);
    issue(8'hAA, 8'h55, 1'b0, 16'h3872, 1'b1); wait_drain();

    // Operand changes after capture are ignored.
    issue(8'h5A, 8'h3C, 1'b0, 16'h1518, 1'b1);
    scramble(W + 2);
    wait_drain();

    // Backpressure: hold DONE for 5 cycles with in_valid asserted.
    out_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_done", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of an operation.
    issue(8'h77, 8'h66, 1'b0, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_prod", 32'(out_prod), 32'd0);
    check("midrst_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    issue(8'd3, 8'd5, 1'b0, 16'h000F, 1'b1); wait_drain();

`ifdef CLMUL_MODE_EN
    // Carry-less products, then the same operands in integer mode.
    issue(8'h03, 8'h03, 1'b1, 16'h0005, 1'b1); wait_drain();
    issue(8'h87, 8'h02, 1'b1, 16'h010E, 1'b1); wait_drain();
    issue(8'hFF, 8'hFF, 1'b1, 16'h5555, 1'b1); wait_drain();
    issue(8'h03, 8'h03, 1'b0, 16'h0009, 1'b1); wait_drain();
    issue(8'h87, 8'h02, 1'b0, 16'h010E, 1'b1); wait_drain();
    issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1); wait_drain();
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
